// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: default width, counter width
// helper and the controller strobe bundle.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  // The counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int mult_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef struct packed {
    logic lm;
    logic lp;
    logic sm;
    logic count;
  } mult_strobe_t;

endpackage

// File: rtl/mult_datapath_if.sv
// Operand, strobe and result bundle between mult_control (master) and
// mult_datapath (slave).
interface mult_datapath_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic [WIDTH-1:0]   multiplicand_in;
  logic [WIDTH-1:0]   multiplier_in;
  logic               lm;
  logic               lp;
  logic               sm;
  logic               count;
  logic               done;
  logic               product_lsb;
  logic [2*WIDTH-1:0] product;

  // Strobes are level-qualified per clock: each is acted on at every rising
  // edge where it is high; there is no handshake back other than done.
  modport master (
    output multiplicand_in, multiplier_in, lm, lp, sm, count,
    input  done, product_lsb, product
  );

  modport slave (
    input  multiplicand_in, multiplier_in, lm, lp, sm, count,
    output done, product_lsb, product
  );

endinterface

// File: rtl/mult_iter_counter.sv
// Saturating iteration counter: cleared by clr, stepped by inc, and flags
// done once it reaches WIDTH.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int CNT_W = mult_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath under mult_control. Optional macro
// MULT_SIGNED_EN selects two's-complement operands via sign/magnitude.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input logic            clk,
  input logic            reset,
  mult_datapath_if.slave dp
);

  localparam int PW = 2 * WIDTH;

  mult_strobe_t stb;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mcand_d;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    prod_d;
  logic             carry_q;
  logic             carry_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   hi_mid;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;

  assign stb = '{lm: dp.lm, lp: dp.lp, sm: dp.sm, count: dp.count};

`ifdef MULT_SIGNED_EN
  logic sign_q;
  logic sign_d;

  // Magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned.
  assign load_a = dp.multiplicand_in[WIDTH-1] ? (~dp.multiplicand_in + 1'b1)
                                              : dp.multiplicand_in;
  assign load_b = dp.multiplier_in[WIDTH-1] ? (~dp.multiplier_in + 1'b1)
                                            : dp.multiplier_in;
`else
  assign load_a = dp.multiplicand_in;
  assign load_b = dp.multiplier_in;
`endif

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    carry_d = carry_q;
`ifdef MULT_SIGNED_EN
    sign_d  = sign_q;
`endif

    // Upper half after the optional add; feeds either the hold or the shift.
    add_sum = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, mcand_q};
    hi_mid  = {carry_q, prod_q[PW-1:WIDTH]};
    if (stb.lp && prod_q[0]) begin
      hi_mid = add_sum;
    end

    if (stb.lm) begin
      mcand_d = load_a;
      prod_d  = {{WIDTH{1'b0}}, load_b};
      carry_d = 1'b0;
`ifdef MULT_SIGNED_EN
      sign_d  = dp.multiplicand_in[WIDTH-1] ^ dp.multiplier_in[WIDTH-1];
`endif
    end else if (stb.sm) begin
      prod_d  = {hi_mid, prod_q[WIDTH-1:1]};
      carry_d = 1'b0;
    end else begin
      {carry_d, prod_d[PW-1:WIDTH]} = hi_mid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      prod_q  <= '0;
      carry_q <= 1'b0;
`ifdef MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      carry_q <= carry_d;
`ifdef MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  mult_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (stb.lm),
    .inc   (stb.count),
    .done  (dp.done)
  );

`ifdef MULT_SIGNED_EN
  assign dp.product = sign_q ? (~prod_q + 1'b1) : prod_q;
`else
  assign dp.product = prod_q;
`endif

  assign dp.product_lsb = prod_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath at WIDTH=32 with hand-computed products.
module tb_mult_datapath;

  localparam int W = 32;

  logic clk;
  logic reset;

  logic [63:0] exp_q[$];
  int          n_total;
  int          n_bad;

  mult_datapath_if #(.WIDTH(W)) dp ();

  mult_datapath #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_strobes(input logic l_m, input logic l_p, input logic s_m, input logic cnt);
    dp.lm    = l_m;
    dp.lp    = l_p;
    dp.sm    = s_m;
    dp.count = cnt;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    dp.multiplicand_in = a;
    dp.multiplier_in   = b;
    set_strobes(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic iterate(input int n);
    set_strobes(1'b0, 1'b1, 1'b1, 1'b1);
    tick(n);
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic iterate_alt(input int n);
    repeat (n) begin
      set_strobes(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1);
      set_strobes(1'b0, 1'b0, 1'b1, 1'b1);
      tick(1);
    end
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp, input bit alt);
    exp_q.push_back(exp);
    load(a, b);
    if (alt) begin
      iterate_alt(31);
    end else begin
      iterate(31);
    end
    check({tag, "_done_early"}, {63'b0, dp.done}, 64'd0);
    if (alt) begin
      iterate_alt(1);
    end else begin
      iterate(1);
    end
    check({tag, "_done"}, {63'b0, dp.done}, 64'd1);
    check({tag, "_prod"}, dp.product, exp_q.pop_front());
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    dp.multiplicand_in = '0;
    dp.multiplier_in   = '0;
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(2);
    check("rst_prod", dp.product, 64'd0);
    check("rst_done", {63'b0, dp.done}, 64'd0);
    check("rst_lsb", {63'b0, dp.product_lsb}, 64'd0);
    reset = 1'b0;
    tick(1);

`ifndef MULT_SIGNED_EN
    // Single-strobe register behaviour on 3 x 5.
    load(32'd3, 32'd5);
    check("lm_prod", dp.product, 64'h0000_0000_0000_0005);
    check("lm_lsb", {63'b0, dp.product_lsb}, 64'd1);
    tick(3);
    check("hold_prod", dp.product, 64'h0000_0000_0000_0005);
    set_strobes(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check("lp_add", dp.product, 64'h0000_0003_0000_0005);
    set_strobes(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    check("sm_shift", dp.product, 64'h0000_0001_8000_0002);
    set_strobes(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check("lp_skip", dp.product, 64'h0000_0001_8000_0002);
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);

    // Carry out of the add lands in the MSB on the following shift.
    load(32'hFFFF_FFFF, 32'd1);
    set_strobes(1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    check("carry_hi", dp.product, 64'hFFFF_FFFE_0000_0001);
    set_strobes(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    check("carry_shift", dp.product, 64'hFFFF_FFFF_0000_0000);
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    run_mult("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);

    // Extra count-only pulses after done.
    set_strobes(1'b0, 1'b0, 1'b0, 1'b1);
    tick(8);
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_done", {63'b0, dp.done}, 64'd1);
    check("post_prod", dp.product, 64'h0000_0000_0000_000F);

`ifdef MULT_SIGNED_EN
    run_mult("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    run_mult("mff_alt", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1);
    run_mult("sneg3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_mult("smin", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
`else
    run_mult("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_mult("mff_alt", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
`endif

    // Reset in the middle of an operation with all strobes high.
    load(32'd7, 32'd9);
    iterate(10);
    set_strobes(1'b0, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_prod", dp.product, 64'd0);
    check("midrst_done", {63'b0, dp.done}, 64'd0);
    check("midrst_lsb", {63'b0, dp.product_lsb}, 64'd0);
    run_mult("m7x9", 32'd7, 32'd9, 64'd63, 1'b0);

    // lm re-asserted mid-operation alongside the other strobes.
    load(32'd6, 32'd6);
    iterate(5);
    dp.multiplicand_in = 32'd2;
    dp.multiplier_in   = 32'd4;
    set_strobes(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    check("relm_prod", dp.product, 64'd4);
    iterate(31);
    check("relm_done_early", {63'b0, dp.done}, 64'd0);
    iterate(1);
    check("relm_done", {63'b0, dp.done}, 64'd1);
    check("relm_prod_final", dp.product, 64'd8);

    // Counter saturation with count-only pulses.
    load(32'd3, 32'd5);
    set_strobes(1'b0, 1'b0, 1'b0, 1'b1);
    tick(31);
    check("sat_done_early", {63'b0, dp.done}, 64'd0);
    tick(9);
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_done", {63'b0, dp.done}, 64'd1);
    tick(2);
    check("sat_done_hold", {63'b0, dp.done}, 64'd1);
`ifdef MULT_SIGNED_EN
    check("sat_prod", dp.product, 64'd5);
`else
    check("sat_prod", dp.product, 64'h0000_0000_0000_0005);
`endif

    // A new lm clears done.
    load(32'd1, 32'd1);
    check("lm_clr_done", {63'b0, dp.done}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
